// File: rtl/readout_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// readout_sequencer_pkg
// Shared record constants and sequencer state encoding.
// Revision: 1.0
// ============================================================================
package readout_sequencer_pkg;

    localparam logic [1:0] HDR_EVENT = 2'b01;
    localparam logic [1:0] HDR_OVR   = 2'b10;
    localparam int         REC_BYTES = 9;

    typedef enum logic [2:0] {
        ST_SCAN   = 3'd0,
        ST_HDR    = 3'd1,
        ST_DATA   = 3'd2,
        ST_UNLOAD = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    function automatic logic [7:0] make_header(input logic [1:0] typ, input logic [2:0] ch);
        return {1'b1, typ, 2'b00, ch};
    endfunction

endpackage
`default_nettype wire

// File: rtl/readout_sequencer_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter
// Combinational round-robin pick: first request at or after i_ptr, mod NCH.
// Revision: 1.0
// ============================================================================
module rr_arbiter
    import readout_sequencer_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0] i_req,
    input  logic [2:0]     i_ptr,
    output logic [NCH-1:0] o_grant,
    output logic [2:0]     o_idx,
    output logic           o_any
);

    localparam logic [NCH-1:0] c_one = NCH'(1);

    logic [NCH-1:0] w_rot;
    logic [3:0]     w_sum;

    always_comb begin
        w_rot   = NCH'({i_req, i_req} >> i_ptr);
        w_sum   = 4'd0;
        o_idx   = 3'd0;
        o_any   = 1'b0;
        // Rotated vector puts i_ptr at bit 0, so the lowest set bit is the winner.
        for (int i = 0; i < NCH; i++) begin
            if (!o_any && w_rot[i]) begin
                o_any = 1'b1;
                w_sum = {1'b0, i_ptr} + 4'(i);
                if (w_sum >= 4'(NCH)) begin
                    w_sum = w_sum - 4'(NCH);
                end
                o_idx = w_sum[2:0];
            end
        end
        o_grant = o_any ? (c_one << o_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/readout_sequencer.sv
`default_nettype none
// ============================================================================
// readout_sequencer
// Round-robin drains per-channel timestamp FIFOs as 9-byte records onto a byte stream.
// Revision: 1.0
// ============================================================================
module readout_sequencer
    import readout_sequencer_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int HOLDCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   attention,
    input  logic [NCH-1:0]   overrun,
    input  logic [8*NCH-1:0] chan_data,
    output logic [2:0]       byteaddr,
    output logic [NCH-1:0]   unload,
    output logic [NCH-1:0]   clearoverrun,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy
);

    localparam int             c_hold_w    = (HOLDCY > 1) ? $clog2(HOLDCY) : 1;
    localparam logic [2:0]     c_last_sent = 3'(REC_BYTES - 2);
    localparam logic [NCH-1:0] c_one       = NCH'(1);

    state_t                r_state;
    logic [2:0]            r_ptr;
    logic [2:0]            r_bidx;
    logic [2:0]            r_sent;
    logic [2:0]            r_cur;
    logic                  r_is_ovr;
    logic [c_hold_w-1:0]   r_hold;

    logic [NCH-1:0]        w_grant;
    logic [2:0]            w_idx;
    logic                  w_any;
    logic                  w_ovr;
    logic [7:0]            w_lane [8];
    logic [7:0]            w_byte;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .i_req   (attention),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    for (genvar g = 0; g < 8; g++) begin : g_lane
        if (g < NCH) begin : g_used
            assign w_lane[g] = chan_data[8*g +: 8];
        end else begin : g_unused
            assign w_lane[g] = 8'h00;
        end
    end

    assign w_byte   = w_lane[r_cur];
    assign w_ovr    = |(w_grant & overrun);
    assign byteaddr = r_bidx;
    assign busy     = (r_state != ST_SCAN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_SCAN;
            r_ptr        <= 3'd0;
            r_bidx       <= 3'd0;
            r_sent       <= 3'd0;
            r_cur        <= 3'd0;
            r_is_ovr     <= 1'b0;
            r_hold       <= '0;
            tx_data      <= 8'h00;
            tx_valid     <= 1'b0;
            unload       <= '0;
            clearoverrun <= '0;
        end else begin
            unload       <= '0;
            clearoverrun <= '0;
            case (r_state)
                ST_SCAN: begin
                    if (w_any) begin
                        r_cur    <= w_idx;
                        r_is_ovr <= w_ovr;
                        tx_data  <= make_header(w_ovr ? HDR_OVR : HDR_EVENT, w_idx);
                        tx_valid <= 1'b1;
                        r_state  <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (tx_ready) begin
                        if (r_is_ovr) begin
                            tx_valid     <= 1'b0;
                            clearoverrun <= c_one << r_cur;
                            r_hold       <= '0;
                            r_state      <= ST_HOLD;
                        end else begin
                            tx_data <= w_byte;
                            r_bidx  <= 3'd1;
                            r_sent  <= 3'd0;
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (tx_ready) begin
                        if (r_sent == c_last_sent) begin
                            tx_valid <= 1'b0;
                            unload   <= c_one << r_cur;
                            r_state  <= ST_UNLOAD;
                        end else begin
                            tx_data <= w_byte;
                            r_bidx  <= r_bidx + 3'd1;
                            r_sent  <= r_sent + 3'd1;
                        end
                    end
                end
                ST_UNLOAD: begin
                    r_hold  <= '0;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Attention is registered upstream, so wait for it to reflect the pop.
                    if (r_hold == c_hold_w'(HOLDCY - 1)) begin
                        r_ptr   <= (r_cur == 3'(NCH - 1)) ? 3'd0 : r_cur + 3'd1;
                        r_bidx  <= 3'd0;
                        r_state <= ST_SCAN;
                    end else begin
                        r_hold <= r_hold + c_hold_w'(1);
                    end
                end
                default: r_state <= ST_SCAN;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_readout_sequencer.sv
`default_nettype none
// ============================================================================
// tb_readout_sequencer
// Scoreboard bench: FIFO/overrun model upstream, byte-stream checker downstream.
// Revision: 1.0
// ============================================================================
module tb_readout_sequencer;

    localparam int NCH    = 4;
    localparam int HOLDCY = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tx_ready = 1'b0;
    logic [NCH-1:0]   attention = '0;
    logic [NCH-1:0]   ovr = '0;
    logic [NCH-1:0]   ovr_set = '0;
    logic [NCH-1:0]   overrun;
    logic [8*NCH-1:0] chan_data;
    logic [2:0]       byteaddr;
    logic [NCH-1:0]   unload;
    logic [NCH-1:0]   clearoverrun;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             busy;

    logic [63:0] mem [NCH][8];
    int          wr [NCH] = '{default: 0};
    int          rd [NCH] = '{default: 0};

    logic [7:0]  exp_q [$];
    logic [7:0]  exp_b;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_acc    = 0;
    int          n_unload [NCH] = '{default: 0};
    int          n_clr    [NCH] = '{default: 0};
    bit          stall_prev = 1'b0;
    logic [7:0]  stall_data = 8'h00;

    assign overrun = ovr;

    readout_sequencer #(.NCH(NCH), .HOLDCY(HOLDCY)) dut (
        .clk          (clk),
        .rst          (rst),
        .attention    (attention),
        .overrun      (overrun),
        .chan_data    (chan_data),
        .byteaddr     (byteaddr),
        .unload       (unload),
        .clearoverrun (clearoverrun),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Upstream model: FIFO pop on unload, latched overrun, registered attention.
    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            rd[i]        <= rd[i] + (unload[i] ? 1 : 0);
            ovr[i]       <= clearoverrun[i] ? 1'b0 : (ovr_set[i] | ovr[i]);
            attention[i] <= (wr[i] != rd[i] + (unload[i] ? 1 : 0)) ||
                            (!clearoverrun[i] && (ovr_set[i] | ovr[i]));
        end
    end

    always_comb begin
        chan_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (wr[i] != rd[i]) begin
                chan_data[8*i +: 8] = 8'(mem[i][rd[i] % 8] >> (8 * byteaddr));
            end
        end
    end

    // Downstream monitor: scoreboard pop on every accepted byte, stall stability, pulse exclusivity.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) begin
                n_checks++;
                if (tx_valid !== 1'b1 || tx_data !== stall_data) begin
                    $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                             tx_valid, tx_data, stall_data);
                end else n_pass++;
            end
            if (tx_valid && tx_ready) begin
                n_acc++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_byte: got %h expected none", tx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (tx_data !== exp_b)
                        $display("FAIL stream_byte: got %h expected %h", tx_data, exp_b);
                    else n_pass++;
                end
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
            n_checks++;
            if ($countones({unload, clearoverrun}) > 1)
                $display("FAIL pulse_onehot: got unload=%b clear=%b expected at most one bit",
                         unload, clearoverrun);
            else n_pass++;
            for (int i = 0; i < NCH; i++) begin
                if (unload[i])       n_unload[i]++;
                if (clearoverrun[i]) n_clr[i]++;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NCH; i++) begin
            n_unload[i] = 0;
            n_clr[i]    = 0;
        end
        n_acc = 0;
    endtask

    task automatic push_event(input int ch, input logic [63:0] v);
        mem[ch][wr[ch] % 8] = v;
        wr[ch] = wr[ch] + 1;
    endtask

    task automatic expect_record(input logic [7:0] hdr, input logic [63:0] v);
        exp_q.push_back(hdr);
        for (int b = 0; b < 8; b++) exp_q.push_back(v[8*b +: 8]);
    endtask

    task automatic wait_idle(input int budget, input bit toggle, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            step();
            tx_ready = toggle ? ~tx_ready : 1'b1;
            if (exp_q.size() == 0 && !busy && !tx_valid) begin
                ok = 1'b1;
                break;
            end
        end
        tx_ready = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_ready = 1'b0;
        repeat (3) step();
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", tx_valid); else n_pass++;
        n_checks++; if (tx_data !== 8'h00) $display("FAIL rst_data: got %h expected 00", tx_data); else n_pass++;
        n_checks++; if (unload !== '0) $display("FAIL rst_unload: got %b expected 0", unload); else n_pass++;
        n_checks++; if (clearoverrun !== '0) $display("FAIL rst_clear: got %b expected 0", clearoverrun); else n_pass++;
        n_checks++; if (byteaddr !== 3'd0) $display("FAIL rst_byteaddr: got %0d expected 0", byteaddr); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_event();
        bit ok;
        logic [63:0] v = 64'h0123_4567_89AB_CDEF;
        clear_counts();
        tx_ready = 1'b1;
        push_event(0, v);
        expect_record(8'hA0, v);
        step();
        n_checks++;
        if (attention[0] !== 1'b1 || tx_valid !== 1'b0)
            $display("FAIL latency_pre: got att=%b valid=%b expected att=1 valid=0", attention[0], tx_valid);
        else n_pass++;
        step();
        n_checks++; if (tx_valid !== 1'b1) $display("FAIL latency_post: got %b expected 1", tx_valid); else n_pass++;
        wait_idle(100, 1'b0, ok);
        n_checks++; if (!ok) $display("FAIL single_done: got timeout expected idle"); else n_pass++;
        n_checks++; if (n_unload[0] !== 1) $display("FAIL single_unload: got %0d expected 1", n_unload[0]); else n_pass++;
        n_checks++; if (n_acc !== 9) $display("FAIL single_len: got %0d expected 9", n_acc); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [63:0] v = 64'h0123_4567_89AB_CDEF;
        clear_counts();
        tx_ready = 1'b0;
        push_event(0, v);
        expect_record(8'hA0, v);
        wait_idle(200, 1'b1, ok);
        n_checks++; if (!ok) $display("FAIL bp_done: got timeout expected idle"); else n_pass++;
        n_checks++; if (n_unload[0] !== 1) $display("FAIL bp_unload: got %0d expected 1", n_unload[0]); else n_pass++;
    endtask

    task automatic test_overrun();
        bit ok;
        logic [63:0] v = 64'hFEDC_BA98_7654_3210;
        clear_counts();
        tx_ready = 1'b1;
        ovr_set[2] = 1'b1;
        push_event(2, v);
        exp_q.push_back(8'hC2);
        expect_record(8'hA2, v);
        step();
        ovr_set = '0;
        wait_idle(200, 1'b0, ok);
        n_checks++; if (!ok) $display("FAIL ovr_done: got timeout expected idle"); else n_pass++;
        n_checks++; if (n_clr[2] !== 1) $display("FAIL ovr_clear: got %0d expected 1", n_clr[2]); else n_pass++;
        n_checks++; if (n_unload[2] !== 1) $display("FAIL ovr_unload: got %0d expected 1", n_unload[2]); else n_pass++;
        n_checks++; if (overrun !== '0) $display("FAIL ovr_flag: got %b expected 0", overrun); else n_pass++;
        n_checks++; if (n_acc !== 10) $display("FAIL ovr_len: got %0d expected 10", n_acc); else n_pass++;
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [63:0] e10 = 64'h1111_0000_AAAA_0001;
        logic [63:0] e11 = 64'h1111_0000_AAAA_0002;
        logic [63:0] e30 = 64'h3333_0000_BBBB_0001;
        logic [63:0] e31 = 64'h3333_0000_BBBB_0002;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        clear_counts();
        tx_ready = 1'b1;
        push_event(1, e10); push_event(1, e11);
        push_event(3, e30); push_event(3, e31);
        expect_record(8'hA1, e10);
        expect_record(8'hA3, e30);
        expect_record(8'hA1, e11);
        expect_record(8'hA3, e31);
        wait_idle(400, 1'b0, ok);
        n_checks++; if (!ok) $display("FAIL rr_done: got timeout expected idle"); else n_pass++;
        n_checks++; if (n_unload[1] !== 2) $display("FAIL rr_unload1: got %0d expected 2", n_unload[1]); else n_pass++;
        n_checks++; if (n_unload[3] !== 2) $display("FAIL rr_unload3: got %0d expected 2", n_unload[3]); else n_pass++;
        n_checks++; if (n_unload[0] + n_unload[2] !== 0)
            $display("FAIL rr_unload_other: got %0d expected 0", n_unload[0] + n_unload[2]); else n_pass++;
    endtask

    task automatic test_reset_mid_record();
        bit ok;
        bit hit = 1'b0;
        logic [63:0] v = 64'h0123_4567_89AB_CDEF;
        clear_counts();
        tx_ready = 1'b1;
        push_event(0, v);
        expect_record(8'hA0, v);
        for (int c = 0; c < 60; c++) begin
            step();
            if (n_acc == 5) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++; if (!hit) $display("FAIL mid_reach: got %0d bytes expected 5", n_acc); else n_pass++;
        n_checks++; if (tx_data !== v[39:32]) $display("FAIL mid_byte4: got %h expected %h", tx_data, v[39:32]); else n_pass++;
        rst = 1'b1;
        step();
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL mid_valid: got %b expected 0", tx_valid); else n_pass++;
        n_checks++; if (unload !== '0) $display("FAIL mid_unload: got %b expected 0", unload); else n_pass++;
        exp_q.delete();
        expect_record(8'hA0, v);
        rst = 1'b0;
        wait_idle(100, 1'b0, ok);
        n_checks++; if (!ok) $display("FAIL mid_resend: got timeout expected idle"); else n_pass++;
        n_checks++; if (n_unload[0] !== 1) $display("FAIL mid_unload_cnt: got %0d expected 1", n_unload[0]); else n_pass++;
    endtask

    task automatic test_no_duplicate();
        bit ok;
        logic [63:0] v = 64'hDEAD_BEEF_CAFE_F00D;
        clear_counts();
        tx_ready = 1'b1;
        push_event(0, v);
        expect_record(8'hA0, v);
        wait_idle(100, 1'b0, ok);
        repeat (30) step();
        n_checks++; if (!ok) $display("FAIL nodup_done: got timeout expected idle"); else n_pass++;
        n_checks++; if (n_unload[0] !== 1) $display("FAIL nodup_unload: got %0d expected 1", n_unload[0]); else n_pass++;
        n_checks++; if (n_acc !== 9) $display("FAIL nodup_len: got %0d expected 9", n_acc); else n_pass++;
        n_checks++; if (attention !== '0) $display("FAIL nodup_att: got %b expected 0", attention); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL nodup_busy: got %b expected 0", busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_backpressure();
        test_overrun();
        test_round_robin();
        test_reset_mid_record();
        test_no_duplicate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
